// File: rtl/g18_flash_reader.sv
// g18_flash_reader: Wishbone classic read-only slave fetching 32-bit words from the 16-bit G18 BPI flash
module g18_flash_reader #(
  parameter int WAIT_CYCLES = 1,
  parameter bit CACHE_EN = 1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [24:0] g18_adr_o,
  input  logic [15:0] g18_dat_i
);
  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [23:0] word, tag;
  logic [15:0] hi;
  logic [31:0] cache_dat;
  logic valid;
  logic req, hit, wait_done;
  logic unused;
  assign unused = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:26], wb_adr_i[1:0]};
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign hit = CACHE_EN && valid && tag == wb_adr_i[25:2];
  assign wait_done = cnt == WC;
  // state register
  always_ff @(posedge sys_clk_i)
    if (!sys_rst_i) state <= IDLE;
    else state <= state_n;
  // next state: writes and hits finish immediately, misses walk both halfwords
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !req ? IDLE : (wb_we_i || hit) ? DONE : HI;
      HI:   state_n = !wb_cyc_i ? IDLE : wait_done ? LO : HI;
      LO:   state_n = !wb_cyc_i ? IDLE : wait_done ? DONE : LO;
      default: state_n = IDLE;
    endcase
  end
  // datapath: flash address, wait counter, halfword assembly, cache and bus responses
  always_ff @(posedge sys_clk_i)
    if (!sys_rst_i) begin
      cnt <= '0;
      word <= '0;
      tag <= '0;
      hi <= '0;
      cache_dat <= '0;
      valid <= 1'b0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      g18_adr_o <= '0;
    end else begin
      case (state)
        IDLE:
          if (req) begin
            if (wb_we_i) wb_err_o <= 1'b1;
            else if (hit) begin
              wb_dat_o <= cache_dat;
              wb_ack_o <= 1'b1;
            end else begin
              g18_adr_o <= {wb_adr_i[25:2], 1'b0};
              word <= wb_adr_i[25:2];
              cnt <= '0;
            end
          end
        HI:
          if (wb_cyc_i) begin
            if (wait_done) begin
              hi <= g18_dat_i;
              g18_adr_o <= {word, 1'b1};
              cnt <= '0;
            end else cnt <= cnt + 4'd1;
          end
        LO:
          if (wb_cyc_i) begin
            if (wait_done) begin
              wb_dat_o <= {hi, g18_dat_i};
              wb_ack_o <= 1'b1;
              tag <= word;
              cache_dat <= {hi, g18_dat_i};
              valid <= 1'b1;
            end else cnt <= cnt + 4'd1;
          end
        default: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
        end
      endcase
    end
endmodule
